arbitro_vc_router: RTL and testbench

- Parametrised successor of the two-VC arbiter/demux in the transmission layer.
- Pulls words from NUM_VC virtual-channel FIFOs and issues at most one pop per cycle, chosen by strict priority or round-robin.
- Routes each popped word to one of NUM_DEST destination FIFOs, selected by a destination field inside the word.
- Owns the pop-delay pipeline internally and honours destination almost-full backpressure; sits between the VC FIFOs and the D-FIFOs.

---
 rtl/arbitro_vc_router_pkg.sv | 19 +
 rtl/arbitro_vc_router_if.sv | 30 +++
 rtl/arbitro_rr_grant.sv | 46 ++++
 rtl/arbitro_vc_router.sv | 115 +++++++++++
 tb/tb_arbitro_vc_router.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/arbitro_vc_router_pkg.sv
// Shared constants and helpers for the VC-to-destination router and its FIFO wrappers.
package arbitro_vc_router_pkg;

    localparam int DATA_WIDTH_DEF = 6;
    localparam int DEST_LSB_DEF   = 4;
    localparam int MODE_STRICT    = 0;
    localparam int MODE_RR        = 1;

    typedef enum logic {
        ARB_STRICT = 1'b0,
        ARB_RR     = 1'b1
    } arb_mode_e;

    // Index/field width for n choices; a single choice still needs one bit.
    function automatic int field_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arbitro_vc_router_if.sv
// Bundle of VC-FIFO read side and D-FIFO write side seen by the router.
interface arbitro_vc_router_if #(
    parameter int DATA_WIDTH = arbitro_vc_router_pkg::DATA_WIDTH_DEF,
    parameter int NUM_VC     = 2,
    parameter int NUM_DEST   = 2
) ();
    import arbitro_vc_router_pkg::*;

    logic [NUM_VC*DATA_WIDTH-1:0]   vc_data;
    logic [NUM_VC-1:0]              vc_empty;
    logic [NUM_VC-1:0]              vc_pop;
    logic [NUM_DEST-1:0]            d_almost_full;
    logic [NUM_DEST*DATA_WIDTH-1:0] d_out;
    logic [NUM_DEST-1:0]            d_push;
    logic                           err_drop;
    logic [15:0]                    push_count;

    // Router side
    modport master (
        input  vc_data, vc_empty, d_almost_full,
        output vc_pop, d_out, d_push, err_drop, push_count
    );

    // FIFO / environment side
    modport slave (
        output vc_data, vc_empty, d_almost_full,
        input  vc_pop, d_out, d_push, err_drop, push_count
    );

endinterface

// File: rtl/arbitro_rr_grant.sv
// Single-grant selector over NUM_VC eligible requesters: strict (lowest index) or
// round-robin starting at rr_ptr, plus the pointer value to use after this cycle.
module arbitro_rr_grant
    import arbitro_vc_router_pkg::*;
#(
    parameter int NUM_VC = 2,
    parameter int VC_W   = field_width(NUM_VC)
) (
    input  logic [NUM_VC-1:0] eligible,
    input  logic [VC_W-1:0]   rr_ptr,
    input  arb_mode_e         mode,
    output logic [NUM_VC-1:0] grant,
    output logic [VC_W-1:0]   grant_idx,
    output logic              grant_vld,
    output logic [VC_W-1:0]   rr_ptr_nxt
);

    logic [VC_W-1:0] cand;

    function automatic logic [VC_W-1:0] wrap_add(input logic [VC_W-1:0] base, input int ofs);
        int s;
        s = int'(base) + ofs;
        if (s >= NUM_VC) s = s - NUM_VC;
        return VC_W'(s);
    endfunction

    always_comb begin
        grant      = '0;
        grant_idx  = '0;
        grant_vld  = 1'b0;
        rr_ptr_nxt = rr_ptr;
        cand       = '0;
        for (int k = 0; k < NUM_VC; k++) begin
            cand = (mode == ARB_RR) ? wrap_add(rr_ptr, k) : VC_W'(k);
            if (!grant_vld && eligible[cand]) begin
                grant_vld   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
        // Pointer only moves on an actual round-robin grant.
        if (grant_vld && mode == ARB_RR)
            rr_ptr_nxt = wrap_add(grant_idx, 1);
    end

endmodule

// File: rtl/arbitro_vc_router.sv
// Pops at most one VC FIFO per cycle and routes the popped word, one cycle later,
// to the destination FIFO named by its destination field.
module arbitro_vc_router
    import arbitro_vc_router_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_VC     = 2,
    parameter int NUM_DEST   = 2,
    parameter int DEST_LSB   = DEST_LSB_DEF,
    parameter int RR_MODE    = MODE_STRICT
) (
    input  logic                 clk,
    input  logic                 reset,
    arbitro_vc_router_if.master  bus
);

    localparam int        VC_W   = field_width(NUM_VC);
    localparam int        DEST_W = field_width(NUM_DEST);
    localparam arb_mode_e MODE   = (RR_MODE == MODE_RR) ? ARB_RR : ARB_STRICT;

    function automatic logic dest_in_range(input logic [DEST_W-1:0] dest);
        return int'(dest) < NUM_DEST;
    endfunction

    logic                  stall_p0;
    logic [NUM_VC-1:0]     elig_p0;
    logic [NUM_VC-1:0]     grant_p0;
    logic [VC_W-1:0]       grant_idx_p0;
    logic                  grant_vld_p0;
    logic [VC_W-1:0]       rr_ptr;
    logic [VC_W-1:0]       rr_ptr_nxt;

    logic                  vld_p1;
    logic [VC_W-1:0]       sel_p1;
    logic [DATA_WIDTH-1:0] word_p1;
    logic [DEST_W-1:0]     dest_p1;

    logic [NUM_DEST*DATA_WIDTH-1:0] d_out_nxt, d_out_p2;
    logic [NUM_DEST-1:0]            d_push_nxt, d_push_p2;
    logic                           err_nxt, err_p2;
    logic [15:0]                    cnt_nxt, cnt_p2;

    // Stage 0: arbitration; any almost-full destination freezes all pops.
    assign stall_p0 = |bus.d_almost_full;
    assign elig_p0  = stall_p0 ? '0 : ~bus.vc_empty;

    arbitro_rr_grant #(
        .NUM_VC (NUM_VC),
        .VC_W   (VC_W)
    ) u_grant (
        .eligible   (elig_p0),
        .rr_ptr     (rr_ptr),
        .mode       (MODE),
        .grant      (grant_p0),
        .grant_idx  (grant_idx_p0),
        .grant_vld  (grant_vld_p0),
        .rr_ptr_nxt (rr_ptr_nxt)
    );

    assign bus.vc_pop = grant_p0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            sel_p1 <= '0;
            rr_ptr <= '0;
        end else begin
            vld_p1 <= grant_vld_p0;
            if (grant_vld_p0)
                sel_p1 <= grant_idx_p0;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    // Stage 1: popped word is now on the FIFO read port; decode and route it.
    assign word_p1 = bus.vc_data[int'(sel_p1)*DATA_WIDTH +: DATA_WIDTH];
    assign dest_p1 = word_p1[DEST_LSB +: DEST_W];

    always_comb begin
        d_out_nxt  = '0;
        d_push_nxt = '0;
        err_nxt    = 1'b0;
        cnt_nxt    = cnt_p2;
        if (vld_p1) begin
            if (dest_in_range(dest_p1)) begin
                d_out_nxt[int'(dest_p1)*DATA_WIDTH +: DATA_WIDTH] = word_p1;
                d_push_nxt[dest_p1] = 1'b1;
                cnt_nxt = cnt_p2 + 16'd1;
            end else begin
                err_nxt = 1'b1;
            end
        end
    end

    // Stage 2: registered outputs toward the destination FIFOs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_out_p2  <= '0;
            d_push_p2 <= '0;
            err_p2    <= 1'b0;
            cnt_p2    <= '0;
        end else begin
            d_out_p2  <= d_out_nxt;
            d_push_p2 <= d_push_nxt;
            err_p2    <= err_nxt;
            cnt_p2    <= cnt_nxt;
        end
    end

    assign bus.d_out      = d_out_p2;
    assign bus.d_push     = d_push_p2;
    assign bus.err_drop   = err_p2;
    assign bus.push_count = cnt_p2;

endmodule

// File: tb/tb_arbitro_vc_router.sv
// Bench for arbitro_vc_router: a strict 2-VC/2-dest instance and a round-robin
// 4-VC/3-dest instance, both checked against a queue-based reference model.
module tb_arbitro_vc_router;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    arbitro_vc_router_if #(.DATA_WIDTH(6), .NUM_VC(2), .NUM_DEST(2)) bus_s ();
    arbitro_vc_router_if #(.DATA_WIDTH(6), .NUM_VC(4), .NUM_DEST(3)) bus_r ();

    arbitro_vc_router #(.DATA_WIDTH(6), .NUM_VC(2), .NUM_DEST(2), .DEST_LSB(4), .RR_MODE(0))
        dut_s (.clk(clk), .reset(reset), .bus(bus_s));
    arbitro_vc_router #(.DATA_WIDTH(6), .NUM_VC(4), .NUM_DEST(3), .DEST_LSB(4), .RR_MODE(1))
        dut_r (.clk(clk), .reset(reset), .bus(bus_r));

    int n_vec = 0;
    int n_err = 0;

    // Reference model: index 0 = strict instance, 1 = round-robin instance.
    int          nvc   [2] = '{2, 4};
    int          ndest [2] = '{2, 3};
    int          mode  [2] = '{0, 1};
    logic [5:0]  mem   [2][4][256];
    int          rd    [2][4];
    int          wr    [2][4];
    int          ptr   [2];
    bit          pend_v[2];
    logic [5:0]  pend_w[2];
    int          cnt   [2];
    logic [3:0]  af    [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int dest_of(input int k, input logic [5:0] w);
        int dw;
        dw = (ndest[k] <= 2) ? 1 : $clog2(ndest[k]);
        return int'(w >> 4) & ((1 << dw) - 1);
    endfunction

    function automatic int model_grant(input int k);
        int c;
        if (af[k] != 4'd0) return -1;
        for (int j = 0; j < nvc[k]; j++) begin
            c = (mode[k] == 1) ? (ptr[k] + j) % nvc[k] : j;
            if (wr[k][c] > rd[k][c]) return c;
        end
        return -1;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < 2; i++) bus_s.vc_empty[i] = (rd[0][i] == wr[0][i]);
        for (int i = 0; i < 4; i++) bus_r.vc_empty[i] = (rd[1][i] == wr[1][i]);
        bus_s.d_almost_full = af[0][1:0];
        bus_r.d_almost_full = af[1][2:0];
    endtask

    task automatic push_word(input int k, input int v, input logic [5:0] w);
        mem[k][v][wr[k][v]] = w;
        wr[k][v]++;
        drive_inputs();
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int v = 0; v < 4; v++) begin
                rd[k][v] = 0;
                wr[k][v] = 0;
            end
            ptr[k]    = 0;
            pend_v[k] = 1'b0;
            pend_w[k] = '0;
            cnt[k]    = 0;
            af[k]     = '0;
        end
        bus_s.vc_data = '0;
        bus_r.vc_data = '0;
        drive_inputs();
    endtask

    // One clock: check pops before the edge, outputs just after it.
    task automatic cycle();
        int          g [2];
        bit          pv[2];
        logic [5:0]  wp[2];
        logic [63:0] ep[2];
        logic [63:0] eo[2];
        bit          ee[2];
        int          d;
        #1;
        for (int k = 0; k < 2; k++) g[k] = model_grant(k);
        check("s_pop", 64'(bus_s.vc_pop), (g[0] < 0) ? 64'd0 : (64'd1 << g[0]));
        check("r_pop", 64'(bus_r.vc_pop), (g[1] < 0) ? 64'd0 : (64'd1 << g[1]));
        for (int k = 0; k < 2; k++) begin
            pv[k] = (g[k] >= 0);
            wp[k] = '0;
            if (pv[k]) begin
                wp[k] = mem[k][g[k]][rd[k][g[k]]];
                rd[k][g[k]]++;
                if (mode[k] == 1) ptr[k] = (g[k] + 1) % nvc[k];
            end
        end
        @(posedge clk);
        #1;
        if (pv[0]) bus_s.vc_data[g[0]*6 +: 6] = wp[0];
        if (pv[1]) bus_r.vc_data[g[1]*6 +: 6] = wp[1];
        drive_inputs();
        for (int k = 0; k < 2; k++) begin
            ep[k] = '0;
            eo[k] = '0;
            ee[k] = 1'b0;
            if (pend_v[k]) begin
                d = dest_of(k, pend_w[k]);
                if (d < ndest[k]) begin
                    ep[k]  = 64'd1 << d;
                    eo[k]  = 64'(pend_w[k]) << (d * 6);
                    cnt[k] = (cnt[k] + 1) % 65536;
                end else begin
                    ee[k] = 1'b1;
                end
            end
            pend_v[k] = pv[k];
            pend_w[k] = wp[k];
        end
        check("s_push", 64'(bus_s.d_push), ep[0]);
        check("s_dout", 64'(bus_s.d_out), eo[0]);
        check("s_err",  64'(bus_s.err_drop), 64'(ee[0]));
        check("s_cnt",  64'(bus_s.push_count), 64'(cnt[0]));
        check("r_push", 64'(bus_r.d_push), ep[1]);
        check("r_dout", 64'(bus_r.d_out), eo[1]);
        check("r_err",  64'(bus_r.err_drop), 64'(ee[1]));
        check("r_cnt",  64'(bus_r.push_count), 64'(cnt[1]));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_s_push"}, 64'(bus_s.d_push), 64'd0);
        check({tag, "_s_dout"}, 64'(bus_s.d_out), 64'd0);
        check({tag, "_s_cnt"},  64'(bus_s.push_count), 64'd0);
        check({tag, "_s_err"},  64'(bus_s.err_drop), 64'd0);
        check({tag, "_r_push"}, 64'(bus_r.d_push), 64'd0);
        check({tag, "_r_dout"}, 64'(bus_r.d_out), 64'd0);
        check({tag, "_r_cnt"},  64'(bus_r.push_count), 64'd0);
        check({tag, "_r_err"},  64'(bus_r.err_drop), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        model_clear();
        #2;
        check_cleared("rst");
        check("rst_s_pop", 64'(bus_s.vc_pop), 64'd0);
        check("rst_r_pop", 64'(bus_r.vc_pop), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Strict priority: VC0 drains before VC1 is served.
        push_word(0, 0, 6'b000101);
        push_word(0, 1, 6'b010011);
        push_word(0, 0, 6'b000111);
        repeat (6) cycle();

        // Routing by destination bit.
        push_word(0, 0, 6'b010110);
        push_word(0, 0, 6'b000110);
        repeat (5) cycle();

        // Backpressure raised one cycle after a pop.
        push_word(0, 0, 6'h05);
        push_word(0, 1, 6'h15);
        push_word(0, 0, 6'h23);
        cycle();
        af[0] = 4'b0001;
        drive_inputs();
        repeat (3) cycle();
        af[0] = 4'b0000;
        drive_inputs();
        repeat (5) cycle();

        // Round-robin over four busy VCs.
        for (int j = 0; j < 2; j++)
            for (int v = 0; v < 4; v++)
                push_word(1, v, {2'((v + j) % 3), 4'(v * 2 + j)});
        repeat (12) cycle();
        check("rr_cnt8", 64'(bus_r.push_count), 64'd8);

        // Out-of-range destination 3 on a 3-destination instance.
        push_word(1, 2, 6'b110001);
        repeat (4) cycle();
        check("oor_cnt_hold", 64'(bus_r.push_count), 64'd8);

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 150; c++) begin
            if ($urandom_range(0, 2) == 0) push_word(0, $urandom_range(0, 1), 6'($urandom));
            if ($urandom_range(0, 1) == 0) push_word(1, $urandom_range(0, 3), 6'($urandom));
            af[0] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 3)) : 4'd0;
            af[1] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 7)) : 4'd0;
            drive_inputs();
            cycle();
        end
        af[0] = '0;
        af[1] = '0;
        drive_inputs();
        repeat (20) cycle();

        // Reset with words in flight.
        for (int v = 0; v < 4; v++) push_word(1, v, 6'(v + 16));
        push_word(0, 1, 6'b010001);
        push_word(0, 0, 6'b000010);
        repeat (2) cycle();
        reset = 1'b1;
        #1;
        check_cleared("mid_rst");
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        for (int v = 0; v < 4; v++) push_word(1, v, 6'(v * 5));
        push_word(0, 1, 6'b010100);
        repeat (8) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
